// File: rtl/grid_locator.sv
// Grid locator: counts dark pixels per grid cell, scans for the busiest cell at each frame edge and reports a debounced index.
// Report is registered E+CELLS+2 after edge cycle E; no backpressure (pixel stream). GRID_LOCATOR_OVERLAY_EN adds a gridline/target overlay on oGrey.
module grid_locator #(
    parameter int DATA_W        = 12,
    parameter int FRAME_W       = 640,
    parameter int FRAME_H       = 480,
    parameter int GRID_COLS     = 3,
    parameter int GRID_ROWS     = 3,
    parameter int THRESH        = 1024,
    parameter int MIN_HITS      = 256,
    parameter int CNT_W         = 18,
    parameter int STABLE_FRAMES = 3
) (
    input  logic                                          iCLK,
    input  logic                                          iRST_N,
    input  logic [DATA_W-1:0]                             iDATA,
    input  logic                                          iDVAL,
    input  logic [15:0]                                   iX_Cont,
    input  logic [15:0]                                   iY_Cont,
    input  logic [31:0]                                   iFrame,
    output logic [$clog2(GRID_COLS*GRID_ROWS+1)-1:0]      oLoc,
    output logic                                          oInt,
    output logic [CNT_W-1:0]                              oMaxCnt,
    output logic                                          oDVAL,
    output logic [DATA_W-1:0]                             oGrey
);
    localparam int CELLS  = GRID_COLS * GRID_ROWS;
    localparam int CELL_W = FRAME_W / GRID_COLS;
    localparam int CELL_H = FRAME_H / GRID_ROWS;
    localparam int LOC_W  = $clog2(CELLS + 1);
    localparam int STB_W  = $clog2(STABLE_FRAMES + 1);
    localparam logic [LOC_W-1:0] NONE    = LOC_W'(CELLS);
    localparam logic [LOC_W-1:0] LAST    = LOC_W'(CELLS - 1);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0]       r_frame;
    logic              r_primed;
    logic              w_edge, w_start;
    logic [31:0]       w_x, w_y, w_data;
    logic              w_in, w_dark, w_hit;
    int                w_col, w_row;
    logic [LOC_W-1:0]  w_idx;
    logic [CNT_W-1:0]  r_cnt  [CELLS];
    logic [CNT_W-1:0]  r_snap [CELLS];
    logic [LOC_W-1:0]  r_idx, r_best, r_prev, r_loc, w_cand;
    logic [CNT_W-1:0]  r_max, r_maxcnt, w_cur;
    logic [STB_W-1:0]  r_stab, w_stab_nxt;
    logic              w_decide, w_report;
    logic              r_int, r_dval;
    logic [DATA_W-1:0] r_grey, w_grey_nxt;

    assign w_x     = {16'b0, iX_Cont};
    assign w_y     = {16'b0, iY_Cont};
    assign w_data  = 32'(iDATA);
    assign w_edge  = (iFrame != r_frame);
    assign w_start = w_edge && r_primed;
    assign w_in    = (w_x < 32'(GRID_COLS * CELL_W)) && (w_y < 32'(GRID_ROWS * CELL_H));
    assign w_dark  = (w_data < 32'(THRESH));
    assign w_hit   = iDVAL && w_in && w_dark;

    // Cell coordinates from threshold compares against cell boundaries
    always_comb begin
        w_col = 0;
        w_row = 0;
        for (int k = 1; k < GRID_COLS; k++)
            if (w_x >= 32'(k * CELL_W)) w_col = k;
        for (int k = 1; k < GRID_ROWS; k++)
            if (w_y >= 32'(k * CELL_H)) w_row = k;
        w_idx = LOC_W'(w_row * GRID_COLS + w_col);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_frame  <= '0;
            r_primed <= 1'b0;
            for (int i = 0; i < CELLS; i++) begin
                r_cnt[i]  <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            r_frame  <= iFrame;
            r_primed <= r_primed || w_edge;
            for (int i = 0; i < CELLS; i++) begin
                if (w_edge)
                    r_cnt[i] <= (w_hit && w_idx == LOC_W'(i)) ? CNT_W'(1) : '0;
                else if (w_hit && w_idx == LOC_W'(i) && r_cnt[i] != '1)
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                if (w_start) r_snap[i] <= r_cnt[i];
            end
        end
    end

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < CELLS; i++)
            if (r_idx == LOC_W'(i)) w_cur = r_snap[i];
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_SCAN;
            S_SCAN:   if (!w_start && r_idx == LAST) w_state_nxt = S_DECIDE;
            S_DECIDE: w_state_nxt = w_start ? S_SCAN : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // A new edge during SCAN/DECIDE pre-empts the decision in flight
    assign w_decide   = (r_state == S_DECIDE) && !w_start;
    assign w_cand     = (32'(r_max) >= 32'(MIN_HITS)) ? r_best : NONE;
    assign w_stab_nxt = (w_cand != r_prev)  ? STB_W'(1) :
                        (r_stab == STB_MAX) ? STB_MAX   : r_stab + STB_W'(1);
    assign w_report   = w_decide && (w_stab_nxt == STB_MAX) && (w_cand != r_loc);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_idx    <= '0;
            r_max    <= '0;
            r_best   <= '0;
            r_prev   <= NONE;
            r_stab   <= '0;
            r_loc    <= NONE;
            r_int    <= 1'b0;
            r_maxcnt <= '0;
        end else begin
            r_int <= 1'b0;
            if (w_start) begin
                r_idx  <= '0;
                r_max  <= '0;
                r_best <= '0;
            end else if (r_state == S_SCAN) begin
                if (w_cur > r_max) begin
                    r_max  <= w_cur;
                    r_best <= r_idx;
                end
                r_idx <= r_idx + LOC_W'(1);
            end
            if (w_decide) begin
                r_prev   <= w_cand;
                r_stab   <= w_stab_nxt;
                r_maxcnt <= r_max;
            end
            if (w_report) begin
                r_loc <= w_cand;
                r_int <= (w_cand != NONE);
            end
        end
    end

`ifdef GRID_LOCATOR_OVERLAY_EN
    logic w_grid, w_mark;
    always_comb begin
        w_grid = 1'b0;
        for (int k = 0; k * CELL_W < FRAME_W; k++)
            if (w_x == 32'(k * CELL_W)) w_grid = 1'b1;
        for (int k = 0; k * CELL_H < FRAME_H; k++)
            if (w_y == 32'(k * CELL_H)) w_grid = 1'b1;
    end
    assign w_mark     = w_in && w_dark && (w_idx == r_loc);
    assign w_grey_nxt = w_grid ? '1 : (w_mark ? '0 : iDATA);
`else
    assign w_grey_nxt = iDATA;
`endif

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_dval <= 1'b0;
            r_grey <= '0;
        end else begin
            r_dval <= iDVAL;
            r_grey <= w_grey_nxt;
        end
    end

    assign oLoc    = r_loc;
    assign oInt    = r_int;
    assign oMaxCnt = r_maxcnt;
    assign oDVAL   = r_dval;
    assign oGrey   = r_grey;
endmodule

// File: tb/tb_grid_locator.sv
// Randomized bench for grid_locator on a small 25x19 frame, checked cycle by cycle against a frame-level reference model.
module tb_grid_locator;
    localparam int DATA_W   = 12;
    localparam int FRAME_W  = 25;
    localparam int FRAME_H  = 19;
    localparam int COLS     = 3;
    localparam int ROWS     = 3;
    localparam int THRESH   = 1024;
    localparam int MIN_HITS = 10;
    localparam int CNT_W    = 5;
    localparam int STABLE   = 3;
    localparam int CELLS    = COLS * ROWS;
    localparam int CW       = FRAME_W / COLS;
    localparam int CH       = FRAME_H / ROWS;
    localparam int NONE     = CELLS;
    localparam int SAT      = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] data;
    logic              dval;
    logic [15:0]       px, py;
    logic [31:0]       frame;
    logic [3:0]        o_loc;
    logic              o_int;
    logic [CNT_W-1:0]  o_maxcnt;
    logic              o_dval;
    logic [DATA_W-1:0] o_grey;

    always #5 clk = ~clk;

    grid_locator #(
        .DATA_W(DATA_W), .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .GRID_COLS(COLS),
        .GRID_ROWS(ROWS), .THRESH(THRESH), .MIN_HITS(MIN_HITS), .CNT_W(CNT_W),
        .STABLE_FRAMES(STABLE)
    ) dut (
        .iCLK(clk), .iRST_N(rst_n), .iDATA(data), .iDVAL(dval), .iX_Cont(px),
        .iY_Cont(py), .iFrame(frame), .oLoc(o_loc), .oInt(o_int),
        .oMaxCnt(o_maxcnt), .oDVAL(o_dval), .oGrey(o_grey)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    // Reference model: per-frame hit tallies, pending decision with a due cycle
    int          m_cnt  [CELLS];
    int          m_snap [CELLS];
    bit          m_primed, m_pend, m_int, m_dval;
    logic [31:0] m_frame_prev;
    int          m_due, m_cyc, m_prev, m_stab, m_loc, m_maxcnt, m_grey;
    int          dens [CELLS];
    int          frame_no = 0;

    task automatic model_reset();
        for (int i = 0; i < CELLS; i++) m_cnt[i] = 0;
        m_primed = 0; m_pend = 0; m_int = 0; m_dval = 0;
        m_frame_prev = 0; m_due = 0; m_cyc = 0;
        m_prev = NONE; m_stab = 0; m_loc = NONE; m_maxcnt = 0; m_grey = 0;
    endtask

    task automatic model_decide();
        int best, mx, cand;
        best = 0;
        mx   = m_snap[0];
        for (int i = 1; i < CELLS; i++)
            if (m_snap[i] > mx) begin mx = m_snap[i]; best = i; end
        cand = (mx >= MIN_HITS) ? best : NONE;
        if (cand == m_prev) m_stab = (m_stab + 1 > STABLE) ? STABLE : m_stab + 1;
        else                m_stab = 1;
        m_prev   = cand;
        m_maxcnt = mx;
        if (m_stab == STABLE && cand != m_loc) begin
            m_loc = cand;
            m_int = (cand != NONE);
        end
    endtask

    task automatic model_step();
        int x, y, d, idx;
        bit in_g, hit, fr_edge;
        x = int'(px); y = int'(py); d = int'(data);
        in_g    = (x < COLS * CW) && (y < ROWS * CH);
        idx     = in_g ? (y / CH) * COLS + (x / CW) : 0;
        hit     = dval && in_g && (d < THRESH);
        fr_edge = (frame != m_frame_prev);
        m_dval  = dval;
`ifdef GRID_LOCATOR_OVERLAY_EN
        if (x % CW == 0 || y % CH == 0)             m_grey = (1 << DATA_W) - 1;
        else if (in_g && idx == m_loc && d < THRESH) m_grey = 0;
        else                                         m_grey = d;
`else
        m_grey = d;
`endif
        m_int = 0;
        if (fr_edge) begin
            if (m_primed) begin
                m_snap = m_cnt;
                m_pend = 1;
                m_due  = m_cyc + CELLS + 1;
            end
            m_primed = 1;
            for (int i = 0; i < CELLS; i++) m_cnt[i] = 0;
            if (hit) m_cnt[idx] = 1;
        end else begin
            if (m_pend && m_cyc == m_due) begin
                model_decide();
                m_pend = 0;
            end
            if (hit && m_cnt[idx] < SAT) m_cnt[idx]++;
        end
        m_frame_prev = frame;
        m_cyc++;
    endtask

    task automatic compare_all();
        check_eq("loc",    32'(o_loc),    32'(m_loc));
        check_eq("int",    32'(o_int),    32'(m_int));
        check_eq("maxcnt", 32'(o_maxcnt), 32'(m_maxcnt));
        check_eq("dval",   32'(o_dval),   32'(m_dval));
        check_eq("grey",   32'(o_grey),   32'(m_grey));
    endtask

    task automatic pixel(input bit dv, input int d, input int x, input int y);
        dval = dv; data = DATA_W'(d); px = 16'(x); py = 16'(y);
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic rand_pixel(input int x, input int y);
        int p, d;
        bit dk;
        p  = (x < COLS * CW && y < ROWS * CH) ? dens[(y / CH) * COLS + x / CW] : 20;
        dk = ($urandom_range(99) < p);
        d  = dk ? int'($urandom_range(THRESH - 1)) : int'($urandom_range(4095, THRESH));
        pixel($urandom_range(9) != 0, d, x, y);
    endtask

    task automatic set_target(input int t, input int pct);
        for (int i = 0; i < CELLS; i++) dens[i] = 0;
        if (t < CELLS) dens[t] = pct;
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) begin
            frame_no++;
            frame = frame_no;
            for (int y = 0; y < FRAME_H; y++)
                for (int x = 0; x < FRAME_W; x++) rand_pixel(x, y);
            for (int b = 0; b < 3; b++) pixel(0, $urandom_range(4095), FRAME_W, FRAME_H);
        end
    endtask

    initial begin
        rst_n = 1'b0; dval = 1'b0; data = '0; px = '0; py = '0; frame = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_loc",    32'(o_loc),    NONE);
        check_eq("rst_int",    32'(o_int),    0);
        check_eq("rst_maxcnt", 32'(o_maxcnt), 0);
        check_eq("rst_dval",   32'(o_dval),   0);
        check_eq("rst_grey",   32'(o_grey),   0);
        rst_n = 1'b1;

        set_target(4, 95);  run_frames(5);    // first edge primes, then report of cell 4
        set_target(2, 95);  run_frames(4);    // switch after debounce
        set_target(4, 5);   run_frames(4);    // below MIN_HITS -> no target, no pulse
        set_target(8, 100); run_frames(3);
        set_target(0, 100); dens[8] = 100; run_frames(3);  // saturated tie resolves low
        for (int i = 0; i < CELLS; i++) dens[i] = 100;
        run_frames(3);

        // Rapid frame edges pre-empt scans in flight
        set_target(6, 95);
        for (int s = 0; s < 30; s++) begin
            int len;
            frame_no++;
            frame = frame_no;
            len = $urandom_range(3, 14);
            for (int c = 0; c < len; c++)
                rand_pixel($urandom_range(FRAME_W - 1), $urandom_range(FRAME_H - 1));
        end

        // Asynchronous reset mid-frame while a cell is reported
        set_target(4, 95); run_frames(4);
        frame_no++;
        frame = frame_no;
        for (int c = 0; c < 100; c++) rand_pixel(c % FRAME_W, c / FRAME_W);
        rst_n = 1'b0;
        #1;
        check_eq("arst_loc", 32'(o_loc), NONE);
        check_eq("arst_int", 32'(o_int), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        run_frames(4);

        for (int r = 0; r < 20; r++) begin
            set_target($urandom_range(CELLS), $urandom_range(10, 100));
            if ($urandom_range(3) == 0) dens[$urandom_range(CELLS - 1)] = $urandom_range(100);
            run_frames($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
